iop_to_ahb_master: RTL and testbench

IOP_TO_AHB_MASTER -- requirements
Module: iop_to_ahb_master

---
 rtl/iop_to_ahb_master.sv | 218 +++++++++++++++++++++
 tb/tb_iop_to_ahb_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iop_to_ahb_master.sv
// iop_to_ahb_master: bridges a simple valid/ready command/response port onto
// an AHB-Lite master. Single outstanding transfer, byte/halfword/word sizes,
// configurable byte-lane order and a sticky wait-state timeout flag.
module iop_to_ahb_master #(
    parameter int          BE      = 0,
    parameter logic [15:0] TIMEOUT = 16'd256
) (
    input  logic        HCLK,
    input  logic        HRESET,

    input  logic        CMDVALID,
    output logic        CMDREADY,
    input  logic        CMDWRITE,
    input  logic [31:0] CMDADDR,
    input  logic [1:0]  CMDSIZE,
    input  logic [31:0] CMDWDATA,

    output logic        RSPVALID,
    input  logic        RSPREADY,
    output logic [31:0] RSPRDATA,
    output logic        RSPERR,

    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,

    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA,

    output logic        BUSTIMEOUT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [1:0]  hsize_q;
    logic [31:0] wdata_q;

    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [15:0] wait_cnt_q;
    logic [16:0] wait_inc;
    logic        timeout_q;

    logic        illegal;
    logic        accept_ok;
    logic        accept_bad;
    logic        wait_cycle;

    logic [1:0]  lane;
    logic [4:0]  shift;
    logic [31:0] rd_shifted;
    logic [31:0] wdata_lane;
    logic [31:0] rdata_lane;

    assign illegal = (CMDSIZE == 2'd3)
                   || ((CMDSIZE == 2'd2) && (CMDADDR[1:0] != 2'b00))
                   || ((CMDSIZE == 2'd1) && CMDADDR[0]);

    assign accept_ok  = (state_q == ST_IDLE) && CMDVALID && !illegal;
    assign accept_bad = (state_q == ST_IDLE) && CMDVALID && illegal;
    assign wait_cycle = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !HREADY;
    assign wait_inc   = {1'b0, wait_cnt_q} + 17'd1;

    assign HADDR      = haddr_q;
    assign HWRITE     = hwrite_q;
    assign HSIZE      = {1'b0, hsize_q};
    assign HBURST     = 3'b000;
    assign HPROT      = 4'b0011;
    assign HMASTLOCK  = 1'b0;
    assign RSPRDATA   = rsp_rdata_q;
    assign RSPERR     = rsp_err_q;
    assign BUSTIMEOUT = timeout_q;

    assign shift      = {lane, 3'b000};
    assign rd_shifted = HRDATA >> shift;

    // Pick the starting byte lane of the latched transfer; big-endian mirrors it.
    always_comb begin
        lane = 2'b00;
        case (hsize_q)
            2'd0:    lane = (BE != 0) ? ~haddr_q[1:0] : haddr_q[1:0];
            2'd1:    lane = {((BE != 0) ? ~haddr_q[1] : haddr_q[1]), 1'b0};
            default: lane = 2'b00;
        endcase
    end

    // Move write data onto its lane and pull read data off it, zero-filling the rest.
    always_comb begin
        wdata_lane = wdata_q;
        rdata_lane = HRDATA;
        case (hsize_q)
            2'd0: begin
                wdata_lane = {24'd0, wdata_q[7:0]} << shift;
                rdata_lane = {24'd0, rd_shifted[7:0]};
            end
            2'd1: begin
                wdata_lane = {16'd0, wdata_q[15:0]} << shift;
                rdata_lane = {16'd0, rd_shifted[15:0]};
            end
            default: begin
                wdata_lane = wdata_q;
                rdata_lane = HRDATA;
            end
        endcase
    end

    // State register; reset drops any transfer in flight without a response.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state bus/handshake outputs.
    always_comb begin
        state_d  = state_q;
        CMDREADY = 1'b0;
        HTRANS   = 2'b00;
        HWDATA   = 32'd0;
        RSPVALID = 1'b0;
        case (state_q)
            ST_IDLE: begin
                CMDREADY = !HRESET;
                if (CMDVALID) begin
                    state_d = illegal ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: begin
                HTRANS = 2'b10;
                if (HREADY) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                HWDATA = wdata_lane;
                if (HREADY) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                RSPVALID = 1'b1;
                if (RSPREADY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch a legal command; rejected commands leave the address-phase signals untouched.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            haddr_q  <= 32'd0;
            hwrite_q <= 1'b0;
            hsize_q  <= 2'd0;
            wdata_q  <= 32'd0;
        end else if (accept_ok) begin
            haddr_q  <= CMDADDR;
            hwrite_q <= CMDWRITE;
            hsize_q  <= CMDSIZE;
            wdata_q  <= CMDWDATA;
        end
    end

    // Build the response: immediate error for rejects, otherwise captured at data-phase end.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else if (accept_bad) begin
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b1;
        end else if ((state_q == ST_DATA) && HREADY) begin
            rsp_err_q   <= HRESP;
            rsp_rdata_q <= (HRESP || hwrite_q) ? 32'd0 : rdata_lane;
        end
    end

    // Count wait states of the current transfer, saturating at the limit.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt_q <= 16'd0;
        end else if (accept_ok) begin
            wait_cnt_q <= 16'd0;
        end else if (wait_cycle && (wait_cnt_q != TIMEOUT)) begin
            wait_cnt_q <= wait_inc[15:0];
        end
    end

    // Sticky timeout flag: set on the wait cycle that brings the count to the limit.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            timeout_q <= 1'b0;
        end else if (wait_cycle && (wait_inc >= {1'b0, TIMEOUT})) begin
            timeout_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iop_to_ahb_master.sv
// tb_iop_to_ahb_master: drives directed and random commands into a little-endian
// and a big-endian instance sharing one stimulus, and compares both against a
// transaction-level model of the bridge.
module tb_iop_to_ahb_master;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        CMDVALID = 1'b0;
    logic        CMDWRITE = 1'b0;
    logic [31:0] CMDADDR = 32'd0;
    logic [1:0]  CMDSIZE = 2'd0;
    logic [31:0] CMDWDATA = 32'd0;
    logic        RSPREADY = 1'b0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic [31:0] HRDATA = 32'd0;

    logic        cmdready0, rspvalid0, rsperr0, hwrite0, hmastlock0, bustimeout0;
    logic        cmdready1, rspvalid1, rsperr1, hwrite1, hmastlock1, bustimeout1;
    logic [31:0] rsprdata0, haddr0, hwdata0;
    logic [31:0] rsprdata1, haddr1, hwdata1;
    logic [1:0]  htrans0, htrans1;
    logic [2:0]  hsize0, hburst0, hsize1, hburst1;
    logic [3:0]  hprot0, hprot1;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_addr = 32'd0;
    logic        last_write = 1'b0;
    logic [1:0]  last_size = 2'd0;
    bit          exp_to0 = 1'b0;
    bit          exp_to1 = 1'b0;

    localparam int TO0 = 4;
    localparam int TO1 = 6;

    iop_to_ahb_master #(.BE(0), .TIMEOUT(16'd4)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET),
        .CMDVALID(CMDVALID), .CMDREADY(cmdready0), .CMDWRITE(CMDWRITE),
        .CMDADDR(CMDADDR), .CMDSIZE(CMDSIZE), .CMDWDATA(CMDWDATA),
        .RSPVALID(rspvalid0), .RSPREADY(RSPREADY), .RSPRDATA(rsprdata0), .RSPERR(rsperr0),
        .HADDR(haddr0), .HTRANS(htrans0), .HWRITE(hwrite0), .HSIZE(hsize0),
        .HBURST(hburst0), .HPROT(hprot0), .HMASTLOCK(hmastlock0), .HWDATA(hwdata0),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .BUSTIMEOUT(bustimeout0)
    );

    iop_to_ahb_master #(.BE(1), .TIMEOUT(16'd6)) dut1 (
        .HCLK(HCLK), .HRESET(HRESET),
        .CMDVALID(CMDVALID), .CMDREADY(cmdready1), .CMDWRITE(CMDWRITE),
        .CMDADDR(CMDADDR), .CMDSIZE(CMDSIZE), .CMDWDATA(CMDWDATA),
        .RSPVALID(rspvalid1), .RSPREADY(RSPREADY), .RSPRDATA(rsprdata1), .RSPERR(rsperr1),
        .HADDR(haddr1), .HTRANS(htrans1), .HWRITE(hwrite1), .HSIZE(hsize1),
        .HBURST(hburst1), .HPROT(hprot1), .HMASTLOCK(hmastlock1), .HWDATA(hwdata1),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .BUSTIMEOUT(bustimeout1)
    );

    // Free-running bus clock.
    always #5 HCLK = ~HCLK;

    // Hard stop in case the bench itself loses sync with the design.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic int byte_offset(int be, logic [31:0] addr, logic [1:0] size);
        int a;
        a = int'(addr % 32'd4);
        if (size == 2'd0) return (be != 0) ? 3 - a : a;
        if (size == 2'd1) return (be != 0) ? 2 - (a / 2) * 2 : (a / 2) * 2;
        return 0;
    endfunction

    function automatic logic [31:0] size_mask(logic [1:0] size);
        if (size == 2'd0) return 32'h0000_00FF;
        if (size == 2'd1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] exp_wdata(int be, logic [31:0] addr, logic [1:0] size, logic [31:0] wdata);
        return (wdata & size_mask(size)) << (8 * byte_offset(be, addr, size));
    endfunction

    function automatic logic [31:0] exp_rdata(int be, logic [31:0] addr, logic [1:0] size, logic [31:0] rdata);
        return (rdata >> (8 * byte_offset(be, addr, size))) & size_mask(size);
    endfunction

    function automatic bit is_legal(logic [31:0] addr, logic [1:0] size);
        if (size == 2'd3) return 1'b0;
        return (addr % (32'd1 << size)) == 32'd0;
    endfunction

    task automatic checkTimeouts(input string tag);
        checkOutput({tag, "_to_le"}, bustimeout0, exp_to0);
        checkOutput({tag, "_to_be"}, bustimeout1, exp_to1);
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_haddr"}, haddr0, last_addr);
        checkOutput({tag, "_hwrite"}, hwrite0, last_write);
        checkOutput({tag, "_hsize"}, hsize0, {30'd0, last_size});
    endtask

    task automatic resetModel();
        last_addr  = 32'd0;
        last_write = 1'b0;
        last_size  = 2'd0;
        exp_to0    = 1'b0;
        exp_to1    = 1'b0;
    endtask

    task automatic applyReset();
        HRESET = 1'b1;
        CMDVALID = 1'b0;
        @(negedge HCLK);
        resetModel();
        checkOutput("rst_cmdready", cmdready0, 1'b0);
        checkOutput("rst_htrans", htrans0, 2'b00);
        checkOutput("rst_rspvalid", rspvalid0, 1'b0);
        checkOutput("rst_rsprdata", rsprdata0, 32'd0);
        checkOutput("rst_rsperr", rsperr0, 1'b0);
        checkOutput("rst_hwdata", hwdata0, 32'd0);
        checkHeld("rst");
        checkTimeouts("rst");
        HRESET = 1'b0;
        @(negedge HCLK);
        checkOutput("rel_cmdready_le", cmdready0, 1'b1);
        checkOutput("rel_cmdready_be", cmdready1, 1'b1);
    endtask

    // One full command: accept, address phase, data phase, response handshake.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int wait_a, input int wait_d, input bit err,
                                 input int rsp_delay, input bit rst_in_data);
        bit          legal;
        int          waits;
        bit          exp_err;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        legal = is_legal(addr, size);
        waits = 0;

        checkOutput("idle_cmdready", cmdready0, 1'b1);
        checkOutput("idle_rspvalid", rspvalid0, 1'b0);
        CMDVALID = 1'b1;
        CMDWRITE = wr;
        CMDADDR  = addr;
        CMDSIZE  = size;
        CMDWDATA = wdata;
        HREADY   = 1'($urandom_range(0, 1));
        HRESP    = 1'b0;
        @(negedge HCLK);
        CMDVALID = 1'b0;
        CMDWRITE = 1'($urandom_range(0, 1));
        CMDADDR  = $urandom;
        CMDSIZE  = 2'($urandom_range(0, 3));
        CMDWDATA = $urandom;

        if (legal) begin
            last_addr  = addr;
            last_write = wr;
            last_size  = size;
            for (int i = 0; i <= wait_a; i++) begin
                checkOutput("addr_htrans", htrans0, 2'b10);
                checkOutput("addr_htrans_be", htrans1, 2'b10);
                checkHeld("addr");
                checkOutput("addr_hwdata", hwdata0, 32'd0);
                checkOutput("addr_cmdready", cmdready0, 1'b0);
                checkOutput("addr_rspvalid", rspvalid0, 1'b0);
                checkTimeouts("addr");
                HREADY = (i == wait_a);
                HRESP  = 1'b0;
                HRDATA = $urandom;
                @(negedge HCLK);
                if (!HREADY) waits++;
                exp_to0 = exp_to0 || (waits >= TO0);
                exp_to1 = exp_to1 || (waits >= TO1);
            end
            for (int i = 0; i <= wait_d; i++) begin
                checkOutput("data_htrans", htrans0, 2'b00);
                checkOutput("data_hwdata_le", hwdata0, exp_wdata(0, addr, size, wdata));
                checkOutput("data_hwdata_be", hwdata1, exp_wdata(1, addr, size, wdata));
                checkHeld("data");
                checkOutput("data_cmdready", cmdready0, 1'b0);
                checkOutput("data_rspvalid", rspvalid0, 1'b0);
                checkTimeouts("data");
                if (rst_in_data) begin
                    HRESET = 1'b1;
                    HREADY = 1'b1;
                    HRESP  = 1'b0;
                    @(negedge HCLK);
                    resetModel();
                    checkOutput("dr_htrans", htrans0, 2'b00);
                    checkOutput("dr_rspvalid", rspvalid0, 1'b0);
                    checkOutput("dr_cmdready", cmdready0, 1'b0);
                    checkOutput("dr_hwdata", hwdata0, 32'd0);
                    checkHeld("dr");
                    HRESET = 1'b0;
                    HREADY = 1'b0;
                    @(negedge HCLK);
                    checkOutput("dr_rel_cmdready", cmdready0, 1'b1);
                    checkOutput("dr_rel_rspvalid", rspvalid0, 1'b0);
                    checkOutput("dr_rel_htrans", htrans0, 2'b00);
                    checkTimeouts("dr");
                    return;
                end
                HREADY = (i == wait_d);
                HRESP  = err && ((i == wait_d) || (i + 1 == wait_d));
                HRDATA = (i == wait_d) ? rdata : $urandom;
                @(negedge HCLK);
                if (!HREADY) waits++;
                exp_to0 = exp_to0 || (waits >= TO0);
                exp_to1 = exp_to1 || (waits >= TO1);
            end
            exp_err = err;
            exp_rd0 = (err || wr) ? 32'd0 : exp_rdata(0, addr, size, rdata);
            exp_rd1 = (err || wr) ? 32'd0 : exp_rdata(1, addr, size, rdata);
        end else begin
            exp_err = 1'b1;
            exp_rd0 = 32'd0;
            exp_rd1 = 32'd0;
        end

        HRESP = 1'b0;
        for (int i = 0; i <= rsp_delay; i++) begin
            checkOutput("rsp_rspvalid_le", rspvalid0, 1'b1);
            checkOutput("rsp_rspvalid_be", rspvalid1, 1'b1);
            checkOutput("rsp_rsperr", rsperr0, exp_err);
            checkOutput("rsp_rdata_le", rsprdata0, exp_rd0);
            checkOutput("rsp_rdata_be", rsprdata1, exp_rd1);
            checkOutput("rsp_cmdready", cmdready0, 1'b0);
            checkOutput("rsp_htrans", htrans0, 2'b00);
            checkOutput("rsp_hwdata", hwdata0, 32'd0);
            checkHeld("rsp");
            checkTimeouts("rsp");
            RSPREADY = (i == rsp_delay);
            HREADY   = 1'($urandom_range(0, 1));
            HRDATA   = $urandom;
            @(negedge HCLK);
        end
        RSPREADY = 1'b0;
        checkOutput("post_rspvalid", rspvalid0, 1'b0);
        checkOutput("post_cmdready", cmdready0, 1'b1);
    endtask

    // Directed scenarios first, then a randomized mix of sizes, alignments and waits.
    initial begin
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        $display("[TB] starting");
        HRESET = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        applyReset();

        checkOutput("const_hburst", hburst0, 3'b000);
        checkOutput("const_hprot", hprot0, 4'b0011);
        checkOutput("const_hmastlock", hmastlock0, 1'b0);

        applyStimulus(1'b1, 32'h2000_0004, 2'd2, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 32'h4000_0003, 2'd0, 32'h0, 32'hAB00_00AB, 0, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 32'h4000_0002, 2'd1, 32'h0, 32'hCAFE_BEEF, 1, 1, 1'b0, 1, 1'b0);
        applyStimulus(1'b1, 32'h1000_0001, 2'd1, 32'h0000_5A5A, 32'h0, 0, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 32'h1000_0000, 2'd3, 32'h0000_5A5A, 32'h0, 0, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 32'h3000_0001, 2'd0, 32'h0000_00C3, 32'h0, 0, 0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 32'h3000_0008, 2'd2, 32'hDEAD_BEEF, 32'h0, 0, 4, 1'b1, 0, 1'b0);

        applyReset();
        applyStimulus(1'b0, 32'h5000_0000, 2'd2, 32'h0, 32'h8765_4321, 0, 6, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 32'h5000_0004, 2'd2, 32'h0, 32'h1111_2222, 0, 0, 1'b0, 0, 1'b0);

        applyStimulus(1'b0, 32'h6000_0001, 2'd0, 32'h0, 32'h0055_AA00, 0, 0, 1'b0, 5, 1'b0);
        applyStimulus(1'b1, 32'h6000_0004, 2'd2, 32'h0BAD_F00D, 32'h0, 1, 0, 1'b0, 0, 1'b1);
        checkOutput("after_dr_haddr", haddr0, 32'd0);

        for (int t = 0; t < 60; t++) begin
            wr   = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = $urandom;
            if ((size != 2'd3) && ($urandom_range(0, 3) != 0)) begin
                addr = addr & ~((32'd1 << size) - 32'd1);
            end
            applyStimulus(wr, addr, size, $urandom, $urandom,
                          $urandom_range(0, 2), $urandom_range(0, 3),
                          ($urandom_range(0, 5) == 0), $urandom_range(0, 3), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
